// File: rtl/mem_stage.sv
// MEM stage of the in-order pipeline: waits for the data-SRAM response, buffers it
// while WB stalls, extracts load data and drops responses left over from flushed requests.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic [31:0] es_result,
  input  logic        es_mem_req,
  input  logic [4:0]  es_ld_op,
  input  logic        es_rf_we,
  input  logic [4:0]  es_rf_waddr,
  input  logic        es_ex,
  input  logic        es_addr_hs,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  input  logic        except_flush,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [31:0] ms_final_result,
  output logic        ms_rf_we,
  output logic [4:0]  ms_rf_waddr,
  output logic        ms_ex,
  output logic        ms_ld_pending
);

  logic        vld_p0;
  logic [31:0] pc_p0;
  logic [31:0] result_p0;
  logic [4:0]  ld_op_p0;
  logic        rf_we_p0;
  logic [4:0]  waddr_p0;
  logic        ex_p0;
  logic        mem_req_p0;
  logic        buf_valid;
  logic [31:0] rdata_buf;
  logic [1:0]  discard_cnt;

  logic        resp_ok;
  logic        ms_ready_go;
  logic        leave;
  logic        stale_inflight;
  logic [1:0]  flush_inc;
  logic        discard_dec;
  logic [31:0] load_word;

  function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic [1:0] inc,
                                         input logic dec);
    logic [2:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc} - {2'b00, dec};
    return (sum > 3'd3) ? 2'd3 : sum[1:0];
  endfunction

  // op is one-hot {ld_w, ld_h, ld_hu, ld_b, ld_bu}
  function automatic logic [31:0] load_extract(input logic [4:0] op, input logic [1:0] off,
                                               input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    if (op[4])      res = word;
    else if (op[3]) res = {{16{h[15]}}, h};
    else if (op[2]) res = {16'h0000, h};
    else if (op[1]) res = {{24{b[7]}}, b};
    else            res = {24'h000000, b};
    return res;
  endfunction

  // A response only belongs to this stage once every stale one has been swallowed.
  assign resp_ok        = data_sram_data_ok & (discard_cnt == 2'd0);
  assign ms_ready_go    = ~mem_req_p0 | ex_p0 | resp_ok | buf_valid;
  assign ms_allowin     = ~vld_p0 | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = vld_p0 & ms_ready_go;
  assign leave          = ms_to_ws_valid & ws_allowin;

  assign stale_inflight = vld_p0 & mem_req_p0 & ~buf_valid & ~data_sram_data_ok;
  assign flush_inc      = except_flush ? ({1'b0, stale_inflight} + {1'b0, es_addr_hs}) : 2'd0;
  assign discard_dec    = data_sram_data_ok & (discard_cnt != 2'd0);

  assign load_word       = buf_valid ? rdata_buf : data_sram_rdata;
  assign ms_final_result = ((|ld_op_p0) & ~ex_p0) ? load_extract(ld_op_p0, result_p0[1:0], load_word)
                                                  : result_p0;
  assign ms_pc           = pc_p0;
  assign ms_rf_we        = vld_p0 & rf_we_p0;
  assign ms_rf_waddr     = waddr_p0;
  assign ms_ex           = vld_p0 & ex_p0;
  assign ms_ld_pending   = vld_p0 & (|ld_op_p0) & ~ex_p0 & ~resp_ok & ~buf_valid;

  // ---- EX -> MEM stage register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0      <= 1'b0;
      pc_p0       <= '0;
      result_p0   <= '0;
      ld_op_p0    <= '0;
      rf_we_p0    <= 1'b0;
      waddr_p0    <= '0;
      ex_p0       <= 1'b0;
      mem_req_p0  <= 1'b0;
      buf_valid   <= 1'b0;
      discard_cnt <= 2'd0;
    end else begin
      if (except_flush)    vld_p0 <= 1'b0;
      else if (ms_allowin) vld_p0 <= es_to_ms_valid;

      if (es_to_ms_valid & ms_allowin) begin
        pc_p0      <= es_pc;
        result_p0  <= es_result;
        ld_op_p0   <= es_ld_op;
        rf_we_p0   <= es_rf_we;
        waddr_p0   <= es_rf_waddr;
        ex_p0      <= es_ex;
        mem_req_p0 <= es_mem_req;
      end

      discard_cnt <= sat_cnt(discard_cnt, flush_inc, discard_dec);

      if (except_flush | leave)
        buf_valid <= 1'b0;
      else if (resp_ok & vld_p0 & mem_req_p0 & ~ws_allowin)
        buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resp_ok & vld_p0 & mem_req_p0 & ~ws_allowin & ~except_flush & ~leave)
      rdata_buf <= data_sram_rdata;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a word-level model of load extraction
// and a transaction-level view of the handshake.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [31:0] es_result;
  logic        es_mem_req;
  logic [4:0]  es_ld_op;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic        es_ex;
  logic        es_addr_hs;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        except_flush;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [31:0] ms_final_result;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic        ms_ex;
  logic        ms_ld_pending;

  int n_chk;
  int n_fail;

  mem_stage dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_result(es_result), .es_mem_req(es_mem_req), .es_ld_op(es_ld_op),
    .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_ex(es_ex), .es_addr_hs(es_addr_hs),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_allowin(ws_allowin), .except_flush(except_flush), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_pc(ms_pc), .ms_final_result(ms_final_result), .ms_rf_we(ms_rf_we),
    .ms_rf_waddr(ms_rf_waddr), .ms_ex(ms_ex), .ms_ld_pending(ms_ld_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    es_to_ms_valid    = 1'b0;
    es_pc             = '0;
    es_result         = '0;
    es_mem_req        = 1'b0;
    es_ld_op          = '0;
    es_rf_we          = 1'b0;
    es_rf_waddr       = '0;
    es_ex             = 1'b0;
    es_addr_hs        = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ws_allowin        = 1'b1;
    except_flush      = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] op,
                       input logic mreq, input logic ex);
    es_to_ms_valid = 1'b1;
    es_pc          = pc;
    es_result      = res;
    es_ld_op       = op;
    es_mem_req     = mreq;
    es_ex          = ex;
    es_rf_we       = 1'b1;
    es_rf_waddr    = pc[6:2];
    tick;
    es_to_ms_valid = 1'b0;
  endtask

  // kind: 1=ld_w 2=ld_h 3=ld_hu 4=ld_b 5=ld_bu; computed by shift/modulo arithmetic
  function automatic logic [31:0] model_load(input int kind, input logic [31:0] addr,
                                             input logic [31:0] word);
    longint v;
    longint w;
    w = longint'(word);
    if (kind == 1) return word;
    if (kind == 2 || kind == 3) begin
      v = (w >> (16 * int'(addr[1]))) % 65536;
      if (kind == 2 && v >= 32768) v = v - 65536;
    end else begin
      v = (w >> (8 * int'(addr[1:0]))) % 256;
      if (kind == 4 && v >= 128) v = v - 256;
    end
    return v[31:0];
  endfunction

  initial begin
    int          kind;
    int          wait_n;
    int          stall;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] expv;
    logic [4:0]  op;

    n_chk  = 0;
    n_fail = 0;
    idle;
    reset = 1'b1;
    tick;
    tick;
    chk("rst_to_ws_valid", ms_to_ws_valid, 0);
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_pc", ms_pc, 0);
    chk("rst_final", ms_final_result, 0);
    chk("rst_rf_we", ms_rf_we, 0);
    chk("rst_ex", ms_ex, 0);
    chk("rst_ld_pending", ms_ld_pending, 0);
    reset = 1'b0;

    // non-memory instruction
    issue(32'h100, 32'h1234, 5'b00000, 1'b0, 1'b0);
    #1;
    chk("alu_to_ws_valid", ms_to_ws_valid, 1);
    chk("alu_final", ms_final_result, 32'h1234);
    chk("alu_pc", ms_pc, 32'h100);
    chk("alu_rf_we", ms_rf_we, 1);
    chk("alu_waddr", ms_rf_waddr, 0);
    tick;
    chk("alu_left", ms_to_ws_valid, 0);

    // ld_b at offset 3
    issue(32'h104, 32'h1003, 5'b00010, 1'b1, 1'b0);
    #1;
    chk("ldb_wait_valid", ms_to_ws_valid, 0);
    chk("ldb_pending", ms_ld_pending, 1);
    chk("ldb_allowin", ms_allowin, 0);
    tick;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_1234;
    #1;
    chk("ldb_final", ms_final_result, 32'hFFFF_FF80);
    chk("ldb_to_ws_valid", ms_to_ws_valid, 1);
    chk("ldb_pending_done", ms_ld_pending, 0);
    tick;
    idle;
    #1;
    chk("ldb_left", ms_to_ws_valid, 0);

    // ld_hu at offset 2, WB stalled for three cycles
    issue(32'h200, 32'h2002, 5'b00100, 1'b1, 1'b0);
    #1;
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8001_0000;
    #1;
    chk("ldhu_final_direct", ms_final_result, 32'h0000_8001);
    chk("ldhu_to_ws_valid", ms_to_ws_valid, 1);
    tick;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("ldhu_buf_valid", dut.buf_valid, 1);
    chk("ldhu_final_buf", ms_final_result, 32'h0000_8001);
    chk("ldhu_allowin_stall", ms_allowin, 0);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("ldhu_hold", ms_final_result, 32'h0000_8001);
      chk("ldhu_hold_buf", dut.buf_valid, 1);
    end
    ws_allowin = 1'b1;
    #1;
    chk("ldhu_final_release", ms_final_result, 32'h0000_8001);
    chk("ldhu_valid_release", ms_to_ws_valid, 1);
    tick;
    idle;
    #1;
    chk("ldhu_left", ms_to_ws_valid, 0);
    chk("ldhu_buf_cleared", dut.buf_valid, 0);

    // flush with one outstanding load plus one EX handshake
    issue(32'h300, 32'h3000, 5'b10000, 1'b1, 1'b0);
    #1;
    chk("flush_pending", ms_ld_pending, 1);
    except_flush = 1'b1;
    es_addr_hs   = 1'b1;
    tick;
    except_flush = 1'b0;
    es_addr_hs   = 1'b0;
    #1;
    chk("flush_cnt2", dut.discard_cnt, 2);
    chk("flush_valid_gone", ms_to_ws_valid, 0);
    issue(32'h400, 32'h4000, 5'b10000, 1'b1, 1'b0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    #1;
    chk("stale1_ignored", ms_to_ws_valid, 0);
    chk("stale1_pending", ms_ld_pending, 1);
    tick;
    data_sram_data_ok = 1'b0;
    #1;
    chk("flush_cnt1", dut.discard_cnt, 1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h2222_2222;
    #1;
    chk("stale2_ignored", ms_to_ws_valid, 0);
    tick;
    data_sram_data_ok = 1'b0;
    #1;
    chk("flush_cnt0", dut.discard_cnt, 0);
    chk("fresh_wait", ms_to_ws_valid, 0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    #1;
    chk("fresh_valid", ms_to_ws_valid, 1);
    chk("fresh_final", ms_final_result, 32'hCAFE_F00D);
    tick;
    idle;

    // load carrying an exception
    issue(32'h500, 32'h5555, 5'b10000, 1'b1, 1'b1);
    #1;
    chk("ex_to_ws_valid", ms_to_ws_valid, 1);
    chk("ex_flag", ms_ex, 1);
    chk("ex_pending", ms_ld_pending, 0);
    chk("ex_final", ms_final_result, 32'h5555);
    chk("ex_cnt", dut.discard_cnt, 0);
    tick;
    chk("ex_left", ms_to_ws_valid, 0);
    chk("ex_cleared", ms_ex, 0);

    // reset during a wait, then a normal load
    issue(32'h600, 32'h6000, 5'b10000, 1'b1, 1'b0);
    #1;
    chk("midrst_pending", ms_ld_pending, 1);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("midrst_valid", ms_to_ws_valid, 0);
    chk("midrst_pc", ms_pc, 0);
    chk("midrst_final", ms_final_result, 0);
    chk("midrst_rf_we", ms_rf_we, 0);
    chk("midrst_ex", ms_ex, 0);
    chk("midrst_pending0", ms_ld_pending, 0);
    chk("midrst_cnt", dut.discard_cnt, 0);
    chk("midrst_buf", dut.buf_valid, 0);
    chk("midrst_allowin", ms_allowin, 1);
    issue(32'h700, 32'h7001, 5'b00001, 1'b1, 1'b0);
    #1;
    chk("postrst_pending", ms_ld_pending, 1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_AB00;
    #1;
    chk("postrst_final", ms_final_result, 32'h0000_00AB);
    chk("postrst_valid", ms_to_ws_valid, 1);
    tick;
    idle;

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      kind   = $urandom_range(0, 5);
      addr   = $urandom;
      word   = $urandom;
      wait_n = $urandom_range(0, 3);
      stall  = $urandom_range(0, 2);
      op     = (kind == 0) ? 5'b00000 : (5'b10000 >> (kind - 1));
      expv   = (kind == 0) ? addr : model_load(kind, addr, word);
      issue(32'h1000 + 32'(t * 4), addr, op, kind != 0, 1'b0);
      #1;
      if (kind != 0) begin
        for (int w = 0; w < wait_n; w++) begin
          chk("rnd_pending", ms_ld_pending, 1);
          chk("rnd_wait_valid", ms_to_ws_valid, 0);
          tick;
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = word;
      end
      ws_allowin = (stall == 0);
      #1;
      chk("rnd_final", ms_final_result, expv);
      chk("rnd_valid", ms_to_ws_valid, 1);
      for (int s = 0; s < stall; s++) begin
        tick;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = $urandom;
        ws_allowin        = (s == stall - 1);
        #1;
        chk("rnd_final_stall", ms_final_result, expv);
        chk("rnd_valid_stall", ms_to_ws_valid, 1);
      end
      tick;
      idle;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
